// File: rtl/rotation_finder.sv
// rotation_finder
//   Recovers the rotate amount that relates two words. A request captures a
//   reference word, a rotated word and a direction. The block then tests one
//   candidate rotation per cycle and reports the smallest k for which
//   rotating data_ref by k (left when direction=0, right when direction=1)
//   gives data_rot. The result is returned over a valid/ready handshake.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous reset, active-high
//   start_valid    request present
//   start_ready    request can be accepted (IDLE and not in reset)
//   data_ref       unrotated word, captured on accept
//   data_rot       rotated word, captured on accept
//   direction      0 = left-rotate relation, 1 = right, captured on accept
//   done_valid     result available; depends on state only
//   done_ready     consumer takes the result
//   found          1 = a matching rotate amount exists
//   rotate_amount  smallest matching amount; 0 when found=0
//
// Optional feature
//   ROTFIND_POPCOUNT_CHECK_EN: when defined, a request whose two words have
//   different popcounts cannot be a rotation. Such a request skips the search
//   and reports found=0 one cycle after accept.

module rotation_finder #(
    parameter int WIDTH = 32,
    localparam int AW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] data_ref,
    input  logic [WIDTH-1:0] data_rot,
    input  logic             direction,
    output logic             done_valid,
    input  logic             done_ready,
    output logic             found,
    output logic [AW-1:0]    rotate_amount
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    // The last candidate tested has count WIDTH-1. The counter is one bit
    // wider than rotate_amount, so it can hold that value for any WIDTH.
    localparam logic [AW:0] CNT_LAST = (AW+1)'(WIDTH - 1);

    state_t           state_r;
    logic [WIDTH-1:0] rot_r;
    logic             dir_r;
    logic [WIDTH-1:0] cand_r;
    logic [AW:0]      cnt_r;
    logic             found_r;
    logic [AW-1:0]    amount_r;
    logic             done_valid_r;
    logic             accept_s;
    logic             skip_s;

    function automatic logic [WIDTH-1:0] rotl1(input logic [WIDTH-1:0] x);
        return {x[WIDTH-2:0], x[WIDTH-1]};
    endfunction

    function automatic logic [WIDTH-1:0] rotr1(input logic [WIDTH-1:0] x);
        return {x[0], x[WIDTH-1:1]};
    endfunction

    assign start_ready   = (state_r == IDLE) && !rst;
    assign accept_s      = start_valid && start_ready;
    assign done_valid    = done_valid_r;
    assign found         = found_r;
    assign rotate_amount = amount_r;

`ifdef ROTFIND_POPCOUNT_CHECK_EN
    logic skip_r;

    function automatic logic [AW:0] popcount(input logic [WIDTH-1:0] x);
        logic [AW:0] n;
        n = {(AW+1){1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            n = n + (AW+1)'(x[i]);
        end
        return n;
    endfunction

    // Remember whether the accepted pair can be a rotation at all.
    always_ff @(posedge clk) begin
        if (rst) begin
            skip_r <= 1'b0;
        end else if (accept_s) begin
            skip_r <= (popcount(data_ref) != popcount(data_rot));
        end else begin
            skip_r <= skip_r;
        end
    end

    assign skip_s = skip_r;
`else
    assign skip_s = 1'b0;
`endif

    // Request/search/result state machine with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            rot_r        <= {WIDTH{1'b0}};
            dir_r        <= 1'b0;
            cand_r       <= {WIDTH{1'b0}};
            cnt_r        <= {(AW+1){1'b0}};
            found_r      <= 1'b0;
            amount_r     <= {AW{1'b0}};
            done_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        rot_r   <= data_rot;
                        dir_r   <= direction;
                        cand_r  <= data_ref;
                        cnt_r   <= {(AW+1){1'b0}};
                        state_r <= SEARCH;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SEARCH: begin
                    // A match is tested before the limit, so the last
                    // candidate (count WIDTH-1) can still be reported.
                    if (cand_r == rot_r) begin
                        found_r      <= 1'b1;
                        amount_r     <= cnt_r[AW-1:0];
                        done_valid_r <= 1'b1;
                        state_r      <= DONE;
                    end else if (skip_s || (cnt_r == CNT_LAST)) begin
                        found_r      <= 1'b0;
                        amount_r     <= {AW{1'b0}};
                        done_valid_r <= 1'b1;
                        state_r      <= DONE;
                    end else begin
                        cand_r  <= dir_r ? rotr1(cand_r) : rotl1(cand_r);
                        cnt_r   <= cnt_r + (AW+1)'(1);
                        state_r <= SEARCH;
                    end
                end
                DONE: begin
                    // found/rotate_amount stay unchanged while the result waits.
                    if (done_ready) begin
                        done_valid_r <= 1'b0;
                        state_r      <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    done_valid_r <= 1'b0;
                    state_r      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rotation_finder.sv
// Directed testbench for rotation_finder (WIDTH=32). The stimulus pushes
// expected results and completion cycles into a queue. A negedge monitor
// pops an entry and compares it each time a new result appears.

module tb_rotation_finder;

    logic        clk;
    logic        rst;
    logic        start_valid;
    logic        start_ready;
    logic [31:0] data_ref;
    logic [31:0] data_rot;
    logic        direction;
    logic        done_valid;
    logic        done_ready;
    logic        found;
    logic [4:0]  rotate_amount;

    typedef struct {
        logic       f;
        logic [4:0] a;
        int         c;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    bit   seen   = 0;

    rotation_finder #(.WIDTH(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_valid   (start_valid),
        .start_ready   (start_ready),
        .data_ref      (data_ref),
        .data_rot      (data_rot),
        .direction     (direction),
        .done_valid    (done_valid),
        .done_ready    (done_ready),
        .found         (found),
        .rotate_amount (rotate_amount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count rising edges so that completion latency can be checked.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: checks each result once, when it first appears.
    always @(negedge clk) begin
        exp_t e;
        if (done_valid && !seen) begin
            seen = 1;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got found=%0d amt=%0d expected no result",
                         found, rotate_amount);
            end else begin
                e = q.pop_front();
                chk("found", 64'(found), 64'(e.f));
                chk("amount", 64'(rotate_amount), 64'(e.a));
                chk("latency_cycle", 64'(cyc), 64'(e.c));
            end
        end else if (!done_valid) begin
            seen = 0;
        end
    end

    // Issue one request. lat = number of edges after the accept edge at
    // which done_valid must rise.
    task automatic issue(input logic [31:0] r, input logic [31:0] t, input logic d,
                         input logic ef, input logic [4:0] ea, input int lat,
                         input bit push);
        int   guard;
        exp_t e;
        @(negedge clk);
        data_ref    = r;
        data_rot    = t;
        direction   = d;
        start_valid = 1'b1;
        guard = 0;
        while (!start_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("start_ready_wait", 64'(start_ready), 64'd1);
        if (start_ready) begin
            if (push) begin
                e.f = ef;
                e.a = ea;
                e.c = cyc + 1 + lat;
                q.push_back(e);
            end
            @(negedge clk);
        end
        start_valid = 1'b0;
        data_ref    = 32'hDEAD_BEEF;
        data_rot    = 32'h0BAD_F00D;
        direction   = ~d;
    endtask

    task automatic wait_done_valid();
        int guard;
        guard = 0;
        while (!done_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("done_valid_wait", 64'(done_valid), 64'd1);
    endtask

    initial begin
        exp_t e;
        int   guard;
        bit   spurious;
        int   nomatch_lat;

`ifdef ROTFIND_POPCOUNT_CHECK_EN
        nomatch_lat = 1;
`else
        nomatch_lat = 32;
`endif
        rst         = 1'b1;
        start_valid = 1'b0;
        data_ref    = 32'h0;
        data_rot    = 32'h0;
        direction   = 1'b0;
        done_ready  = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_start_ready", 64'(start_ready), 64'd0);
        chk("rst_done_valid", 64'(done_valid), 64'd0);
        chk("rst_found", 64'(found), 64'd0);
        chk("rst_amount", 64'(rotate_amount), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_start_ready", 64'(start_ready), 64'd1);

        // Main function and boundaries
        issue(32'h0000_000F, 32'h0000_03C0, 1'b0, 1'b1, 5'd6, 7, 1);
        issue(32'hF000_000F, 32'hFF00_0000, 1'b1, 1'b1, 5'd4, 5, 1);
        issue(32'h8000_0001, 32'h0000_0003, 1'b0, 1'b1, 5'd1, 2, 1);
        issue(32'h8000_0001, 32'h0000_0003, 1'b1, 1'b1, 5'd31, 32, 1);
        issue(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 5'd0, 1, 1);
        issue(32'hAAAA_AAAA, 32'hAAAA_AAAA, 1'b1, 1'b1, 5'd0, 1, 1);
        issue(32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b1, 5'd1, 2, 1);
        issue(32'h0000_0001, 32'h0000_0003, 1'b0, 1'b0, 5'd0, nomatch_lat, 1);
        issue(32'h1234_5678, 32'h7812_3456, 1'b1, 1'b1, 5'd8, 9, 1);

        // Result held under backpressure; a pending request must not be accepted
        issue(32'h0000_000F, 32'h0000_03C0, 1'b0, 1'b1, 5'd6, 7, 1);
        done_ready = 1'b0;
        wait_done_valid();
        start_valid = 1'b1;
        data_ref    = 32'h0000_0001;
        data_rot    = 32'h0000_0002;
        direction   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_done_valid", 64'(done_valid), 64'd1);
            chk("hold_found", 64'(found), 64'd1);
            chk("hold_amount", 64'(rotate_amount), 64'd6);
            chk("hold_start_ready", 64'(start_ready), 64'd0);
        end
        done_ready = 1'b1;
        @(negedge clk);
        chk("handoff_done_valid", 64'(done_valid), 64'd0);
        chk("handoff_start_ready", 64'(start_ready), 64'd1);
        e.f = 1'b1;
        e.a = 5'd1;
        e.c = cyc + 1 + 2;
        q.push_back(e);
        @(negedge clk);
        start_valid = 1'b0;
        chk("after_accept_start_ready", 64'(start_ready), 64'd0);

        // Reset during a search aborts it without producing a result
        issue(32'h8000_0001, 32'h0000_0003, 1'b1, 1'b0, 5'd0, 0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_start_ready", 64'(start_ready), 64'd0);
        repeat (3) @(negedge clk);
        chk("midrst_done_valid", 64'(done_valid), 64'd0);
        rst = 1'b0;
        #1;
        chk("postrst_start_ready", 64'(start_ready), 64'd1);
        spurious = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done_valid) spurious = 1;
        end
        chk("postrst_no_result", 64'(spurious), 64'd0);
        issue(32'h1234_5678, 32'h7812_3456, 1'b1, 1'b1, 5'd8, 9, 1);

        // Drain the scoreboard
        guard = 0;
        while (q.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got cycle %0d expected completion", cyc);
        $fatal(1);
    end

endmodule
